vga_frame_reader_640x480: RTL and testbench
===========================================

# vga_frame_reader_640x480

Read-side scan engine for the 320x240 24-bit frame buffer. Generates 640x480@60 Hz VGA timing, issues frame-buffer read addresses with 2x pixel/line replication, and drives ADV7123 DAC RGB and sync/blank outputs. It is pipeline-aligned to the buffer's one-cycle registered read latency. It sits between the frame buffer read port and the board VGA pins, clocked by the 25.175 MHz pixel clock.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

- piul1Clock  in  1  pixel clock; also drives the frame buffer read clock
- piul1Reset  in  1  synchronous, active-high reset
- piul1Enable  in  1  1 = display buffer contents; 0 = output black, timing keeps running
- poul17ReadAddress  out  17  frame-buffer read address, 0..76799
- piul24ReadData  in  24  frame-buffer read data {R[23:16], G[15:8], B[7:0]}, valid one cycle after the address
- poul8Red / poul8Green / poul8Blue  out  8 each  DAC pixel data
- poul1HSync_n  out  1  horizontal sync, active low
- poul1VSync_n  out  1  vertical sync, active low
- poul1Blank_n  out  1  ADV7123 BLANK_N, 0 outside visible area
- poul1Sync_n  out  1  ADV7123 SYNC_N, tied high (no sync-on-green)
- poul1FrameStart  out  1  one-cycle pulse aligned with the first visible pixel of each frame

## Operation
- Horizontal counter h runs 0..H_TOTAL-1, where H_TOTAL = 800. It wraps to 0 and then increments the vertical counter v, which runs 0..V_TOTAL-1 (V_TOTAL = 525) and wraps to 0.
- Visible when h < H_VISIBLE and v < V_VISIBLE.
- HSync_n is 0 for h in [656, 751]. VSync_n is 0 for v in [490, 491] for the whole line, including the blanking part.
- Source coordinates are x = h>>1 and y = v>>1. Read address = y*320 + x, computed as (y<<8)+(y<<6)+x, 17-bit and unsigned. No multiplier is used.
- The address is 0 when not visible. The maximum visible address is 239*320+319 = 76799. The address never exceeds 76799.
- RGB = piul24ReadData when the aligned visible flag and piul1Enable (aligned) are both 1; otherwise RGB = 0.
- FrameStart = 1 exactly when the aligned (h,v) = (0,0).
- Sync_n is constant 1, including during reset.
- piul1Enable is sampled in stage 0 and pipelined with the timing flags. Toggling it mid-line takes effect on pixel boundaries with the same latency as the timing outputs.

## Timing
- Pipeline:
  - Stage 0: counters (h,v) plus decoded flags.
  - Stage 1: registered address and delayed flags.
  - Stage 2: buffer data is valid.
  - Stage 3: registered RGB, sync and blank outputs.
- All pixel-path outputs (RGB, HSync_n, VSync_n, Blank_n, FrameStart) reflect counter position (h,v) exactly 3 cycles after the counters hold it. poul17ReadAddress reflects it 1 cycle after.
- Sync and blank are delayed through the same 3-stage pipeline as the data. They are never decoded directly onto the pins.
- Reset values:
  - h = 0, v = 0, all pipeline stages cleared.
  - poul17ReadAddress = 0; RGB = 0.
  - HSync_n = 1, VSync_n = 1, Blank_n = 0, FrameStart = 0, Sync_n = 1.
- The first cycle after reset deassertion has counters at (0,0). The first FrameStart pulse occurs 3 cycles after that.
- Reset asserted mid-frame returns everything to the reset values on the next edge. The pipeline is flushed, and no stale pixel or sync pulse appears after release.
- Wrap-around: at h = 799, v = 524 the next cycle is (0,0). The frame period is exactly 420000 cycles.

## Test plan
- Reset, then run 2 frames.
  - HSync_n low for 96 cycles every 800 cycles.
  - VSync_n low for 1600 cycles every 420000 cycles.
  - Blank_n high for 640 cycles per line on 480 lines.
  - FrameStart pulses every 420000 cycles, first at cycle 3 after release.
- Address sequence on line v=0: 0,0,1,1,…,319,319, then 0 in blanking. Lines v=1 and v=2 start at 0 and 320. The last visible pixel, v=479 h=639, gives 76799.
- Frame-buffer model with data = address (24-bit), 1-cycle latency. The RGB at visible pixel (h,v) equals (v>>1)*320+(h>>1). Sync and blank edges line up with the first/last valid pixel with zero skew.
- piul1Enable = 0 for one whole line: RGB = 0 throughout, sync and blank unchanged. Re-enable: pixels reappear 3 cycles after the enable edge's aligned position.
- Assert piul1Reset for 1 cycle at (h,v) = (300,100):
  - next cycle the outputs are at reset values (Blank_n = 0, syncs = 1, RGB = 0);
  - after release the counters restart at (0,0) and the frame period is restored.
- Check the wrap boundary: the transition from (799,524) to (0,0) produces no extra or missing hsync, and the address returns to 0 at the first visible pixel.

Source files
------------

// File: rtl/vga_frame_reader_640x480.sv
// VGA 640x480 scan engine reading a 320x240 24-bit frame buffer with 2x
// pixel/line replication. The counters and their decoded flags form stage 0.
// The address and flags are registered in stage 1. Buffer data arrives in
// stage 2. RGB, sync and blank are registered onto the pins in stage 3, so
// the syncs stay aligned with the pixels they frame.
module vga_frame_reader_640x480 #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        piul1Clock,
    input  logic        piul1Reset,
    input  logic        piul1Enable,
    output logic [16:0] poul17ReadAddress,
    input  logic [23:0] piul24ReadData,
    output logic [7:0]  poul8Red,
    output logic [7:0]  poul8Green,
    output logic [7:0]  poul8Blue,
    output logic        poul1HSync_n,
    output logic        poul1VSync_n,
    output logic        poul1Blank_n,
    output logic        poul1Sync_n,
    output logic        poul1FrameStart
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Stage 0: scan counters and decoded flags
    logic [9:0]  h_cnt_r;
    logic [9:0]  v_cnt_r;
    logic        visible_s;
    logic        hsync_s;
    logic        vsync_s;
    logic        frame_start_s;
    logic [8:0]  src_x_s;
    logic [8:0]  src_y_s;
    logic [16:0] addr_s;

    // Stage 1: registered address and flags
    logic [16:0] addr_r;
    logic        visible1_r;
    logic        hsync1_r;
    logic        vsync1_r;
    logic        frame_start1_r;
    logic        enable1_r;

    // Stage 2: flags waiting for the buffer data
    logic        visible2_r;
    logic        hsync2_r;
    logic        vsync2_r;
    logic        frame_start2_r;
    logic        enable2_r;

    // Stage 3: pin registers
    logic [23:0] rgb_r;
    logic        hsync_n_r;
    logic        vsync_n_r;
    logic        blank_n_r;
    logic        frame_start_r;

    // Scan position: h wraps at end of line and advances v, v wraps at end of frame
    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= 10'd0;
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= 10'd0;
            end else begin
                v_cnt_r <= v_cnt_r + 10'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 10'd1;
        end
    end

    // Decode the region flags and the replicated source address from the counters
    always_comb begin
        visible_s     = (h_cnt_r < H_VIS_END) && (v_cnt_r < V_VIS_END);
        hsync_s       = (h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_LAST);
        vsync_s       = (v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_LAST);
        frame_start_s = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
        src_x_s       = h_cnt_r[9:1];
        src_y_s       = v_cnt_r[9:1];
        if (visible_s) begin
            // y*320 + x as y*256 + y*64 + x, shift-and-add only
            addr_s = {src_y_s, 8'h00} + {2'b00, src_y_s, 6'h00} + {8'h00, src_x_s};
        end else begin
            addr_s = 17'd0;
        end
    end

    // Stages 1 and 2: register the address and carry the flags alongside the buffer latency
    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            addr_r         <= 17'd0;
            visible1_r     <= 1'b0;
            hsync1_r       <= 1'b0;
            vsync1_r       <= 1'b0;
            frame_start1_r <= 1'b0;
            enable1_r      <= 1'b0;
            visible2_r     <= 1'b0;
            hsync2_r       <= 1'b0;
            vsync2_r       <= 1'b0;
            frame_start2_r <= 1'b0;
            enable2_r      <= 1'b0;
        end else begin
            addr_r         <= addr_s;
            visible1_r     <= visible_s;
            hsync1_r       <= hsync_s;
            vsync1_r       <= vsync_s;
            frame_start1_r <= frame_start_s;
            enable1_r      <= piul1Enable;
            visible2_r     <= visible1_r;
            hsync2_r       <= hsync1_r;
            vsync2_r       <= vsync1_r;
            frame_start2_r <= frame_start1_r;
            enable2_r      <= enable1_r;
        end
    end

    // Stage 3: capture buffer data (or black) and drive sync/blank from the delayed flags
    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            rgb_r         <= 24'd0;
            hsync_n_r     <= 1'b1;
            vsync_n_r     <= 1'b1;
            blank_n_r     <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            if (visible2_r && enable2_r) begin
                rgb_r <= piul24ReadData;
            end else begin
                rgb_r <= 24'd0;
            end
            hsync_n_r     <= ~hsync2_r;
            vsync_n_r     <= ~vsync2_r;
            blank_n_r     <= visible2_r;
            frame_start_r <= frame_start2_r;
        end
    end

    assign poul17ReadAddress = addr_r;
    assign poul8Red          = rgb_r[23:16];
    assign poul8Green        = rgb_r[15:8];
    assign poul8Blue         = rgb_r[7:0];
    assign poul1HSync_n      = hsync_n_r;
    assign poul1VSync_n      = vsync_n_r;
    assign poul1Blank_n      = blank_n_r;
    assign poul1FrameStart   = frame_start_r;
    // No sync-on-green: the DAC composite sync input is held inactive at all times
    assign poul1Sync_n       = 1'b1;

endmodule

// File: tb/tb_vga_frame_reader_640x480.sv
// Bench for vga_frame_reader_640x480. Full horizontal timing is kept, and the
// vertical timing is shortened so that several frames fit in a short run. A
// driver sets reset and enable and queues the pin values expected in each
// cycle, computing them from the scan position. A monitor on the falling edge
// pops each expected record and compares it with the pins.
module tb_vga_frame_reader_640x480;

    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 12, VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int MAX_CYC = 80000;

    typedef struct packed {
        logic [16:0] addr;
        logic [23:0] rgb;
        logic        hs_n;
        logic        vs_n;
        logic        blank_n;
        logic        fs;
        logic        sync_n;
    } pins_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [16:0] addr;
    logic [23:0] rdata = 24'd0;
    logic [7:0]  red, green, blue;
    logic        hs_n, vs_n, blank_n, sync_n, fs;

    pins_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    rst_epoch = 0;

    vga_frame_reader_640x480 #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .piul1Clock        (clk),
        .piul1Reset        (rst),
        .piul1Enable       (en),
        .poul17ReadAddress (addr),
        .piul24ReadData    (rdata),
        .poul8Red          (red),
        .poul8Green        (green),
        .poul8Blue         (blue),
        .poul1HSync_n      (hs_n),
        .poul1VSync_n      (vs_n),
        .poul1Blank_n      (blank_n),
        .poul1Sync_n       (sync_n),
        .poul1FrameStart   (fs)
    );

    always #5 clk = ~clk;

    // Frame buffer stand-in: each word holds its own address, with one cycle of read latency
    always @(posedge clk) rdata <= {7'd0, addr};

    // Expected pins for cycle j, where cycle 0 is the first cycle with the counters at (0,0)
    function automatic pins_t expect_pins(int j, bit en_at);
        pins_t e;
        int p, h, v;
        bit vis;
        e.addr = 17'd0; e.rgb = 24'd0; e.hs_n = 1'b1; e.vs_n = 1'b1;
        e.blank_n = 1'b0; e.fs = 1'b0; e.sync_n = 1'b1;
        if (j >= 1) begin
            p = (j - 1) % FRAME; h = p % HT; v = p / HT;
            if (h < HV && v < VV) e.addr = 17'((v / 2) * 320 + h / 2);
        end
        if (j >= 3) begin
            p = (j - 3) % FRAME; h = p % HT; v = p / HT;
            vis = (h < HV) && (v < VV);
            e.rgb     = (vis && en_at) ? 24'((v / 2) * 320 + h / 2) : 24'd0;
            e.hs_n    = !(h >= HV + HF && h < HV + HF + HS);
            e.vs_n    = !(v >= VV + VF && v < VV + VF + VS);
            e.blank_n = vis;
            e.fs      = (p == 0);
        end
        return e;
    endfunction

    task automatic check(string name, bit ok, string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s %s", name, detail);
    endtask

    // Driver: reset, two frames (one dark line, then random enable), mid-frame reset, one more frame
    initial begin : driver
        int  j;
        bit  en_hist[$];
        bit  did_mid_reset;
        bit  done;
        j = 0; did_mid_reset = 1'b0; done = 1'b0;
        for (int c = 0; c < MAX_CYC && !done; c++) begin
            @(posedge clk); #1;
            if (rst) begin
                j = 0;
                en_hist.delete();
                rst_epoch++;
            end else begin
                j++;
            end
            if (!did_mid_reset) begin
                if (j >= 5 * HT && j < 6 * HT)            en = 1'b0;
                else if (j >= FRAME && j < 2 * FRAME)     en = ($urandom_range(0, 63) == 0) ? ~en : en;
                else                                      en = 1'b1;
            end else begin
                en = 1'b1;
            end
            en_hist.push_back(en);
            exp_q.push_back(expect_pins(j, (j >= 3) ? en_hist[j - 3] : 1'b0));
            if (c < 3) begin
                rst = 1'b1;
            end else if (!did_mid_reset && j >= 2 * FRAME && (j % FRAME) == 10 * HT + 300) begin
                rst = 1'b1;
                did_mid_reset = 1'b1;
            end else begin
                rst = 1'b0;
            end
            if (did_mid_reset && !rst && j >= FRAME + 2 * HT) done = 1'b1;
        end
        @(negedge clk); #1;
        check("run_complete", done && exp_q.size() == 0,
              $sformatf("got done=%0d queued=%0d, need done=1 queued=0", done, exp_q.size()));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Monitor: per-cycle pin comparison plus hsync width and frame period checks
    initial begin : monitor
        pins_t got, e;
        int mon_cyc, hs_run, last_fs, last_epoch;
        mon_cyc = 0; hs_run = 0; last_fs = -1; last_epoch = -1;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                got.addr = addr; got.rgb = {red, green, blue}; got.hs_n = hs_n;
                got.vs_n = vs_n; got.blank_n = blank_n; got.fs = fs; got.sync_n = sync_n;
                check("pins", got === e,
                      $sformatf("cyc=%0d got addr=%0d rgb=%0d hs=%b vs=%b bl=%b fs=%b sy=%b need addr=%0d rgb=%0d hs=%b vs=%b bl=%b fs=%b sy=%b",
                                mon_cyc, got.addr, got.rgb, got.hs_n, got.vs_n, got.blank_n, got.fs, got.sync_n,
                                e.addr, e.rgb, e.hs_n, e.vs_n, e.blank_n, e.fs, e.sync_n));
                if (hs_n === 1'b0) begin
                    hs_run++;
                end else if (hs_run > 0) begin
                    check("hsync_width", hs_run == HS,
                          $sformatf("cyc=%0d got %0d low cycles, need %0d", mon_cyc, hs_run, HS));
                    hs_run = 0;
                end
                if (fs === 1'b1) begin
                    if (last_fs >= 0 && last_epoch == rst_epoch)
                        check("frame_period", (mon_cyc - last_fs) == FRAME,
                              $sformatf("got %0d cycles, need %0d", mon_cyc - last_fs, FRAME));
                    last_fs = mon_cyc;
                    last_epoch = rst_epoch;
                end
            end
        end
    end

endmodule
